rr_decode_arbiter: RTL

- Round-robin arbiter sharing one 8-way decoded resource (3-bit select plus enable into a 3-to-8 one-hot decoder) among 8 requesters.
- Grants one requester at a time.
- Holds the grant until that requester drops its request.
- Drives registered select, enable and one-hot outputs directly into the decode stage.

---
 rtl/rr_decode_arbiter_if.sv | 20 ++
 rtl/rr_decode_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between eight requesters and the round-robin decode arbiter.
// master = requester side (drives req), slave = arbiter side (drives grant outputs).
interface rr_decode_arbiter_if;
  logic [7:0] req;
  logic [2:0] grant_sel;
  logic       grant_en;
  logic [7:0] grant_onehot;
  logic [2:0] ptr;
  logic       timeout_pulse;

  modport master (
    output req,
    input  grant_sel, grant_en, grant_onehot, ptr, timeout_pulse
  );

  modport slave (
    input  req,
    output grant_sel, grant_en, grant_onehot, ptr, timeout_pulse
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// 8-way round-robin arbiter driving a registered select/enable/one-hot decode stage.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_decode_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_decode_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (CNT_W < 1 || HOLD_MAX < 1 || HOLD_MAX > 255 || (64'd1 << CNT_W) <= 64'(HOLD_MAX)) begin : g_cfg_bad
    $error("rr_decode_arbiter: illegal HOLD_MAX/CNT_W combination");
  end

  logic [0:0] state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic       en_q, en_d;
  logic [7:0] oh_q, oh_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] winner;

  // Rotate so bit 0 is the pointer position; the lowest set bit is the winner offset.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [15:0] dbl;
    logic [2:0]  off;
    dbl = {r, r} >> p;
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (dbl[i]) off = 3'(i);
    end
    return p + off;
  endfunction

  assign winner = rr_pick(bus.req, ptr_q);

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             tp_q, tp_d;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    oh_d    = oh_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    tp_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          sel_d   = winner;
          en_d    = 1'b1;
          oh_d    = 8'b1 << winner;
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d  = CNT_W'(1);
`endif
        end
      end
      GRANT: begin
        // Owner dropping its request always wins over a simultaneous timeout.
        if (!bus.req[sel_q]) begin
          en_d    = 1'b0;
          oh_d    = 8'h00;
          ptr_d   = sel_q + 3'd1;
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LIM) begin
          en_d    = 1'b0;
          oh_d    = 8'h00;
          ptr_d   = sel_q + 3'd1;
          state_d = IDLE;
          tp_d    = 1'b1;
        end else if (hold_q != CNT_MAX) begin
          hold_d  = hold_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        oh_d    = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      en_q    <= 1'b0;
      oh_q    <= 8'h00;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      tp_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      tp_q   <= tp_d;
    end
  end

  assign bus.timeout_pulse = tp_q;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

  assign bus.grant_sel    = sel_q;
  assign bus.grant_en     = en_q;
  assign bus.grant_onehot = oh_q;
  assign bus.ptr          = ptr_q;

endmodule
